// File: rtl/conv_out_streamer_if.sv
// Handshake bundle for conv_out_streamer: frame capture side from the PE array
// and the pixel stream side towards pooling/storage.
interface conv_out_streamer_if #(
  parameter int N     = 10,
  parameter int OUT_W = 2
) ();
  logic                   cap_valid;
  logic                   cap_ready;
  logic [N*N*OUT_W-1:0]   conv_out;
  logic                   m_valid;
  logic                   m_ready;
  logic [OUT_W-1:0]       m_data;
  logic [$clog2(N)-1:0]   m_row;
  logic [$clog2(N)-1:0]   m_col;
  logic                   m_last;

  // Streamer side
  modport slave (
    input  cap_valid, conv_out, m_ready,
    output cap_ready, m_valid, m_data, m_row, m_col, m_last
  );

  // Array / downstream side
  modport master (
    output cap_valid, conv_out, m_ready,
    input  cap_ready, m_valid, m_data, m_row, m_col, m_last
  );
endinterface

// File: rtl/conv_out_streamer.sv
// conv_out_streamer: captures one N x N result map in a single cycle and
// streams it out row-major, one pixel per beat, with row/col tags and m_last.
// Optional feature macro: CONV_STREAM_DBLBUF_EN adds a pending frame buffer so
// a new frame can be taken while streaming and frames chain with no bubble.
module conv_out_streamer #(
  parameter int N     = 10,
  parameter int OUT_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  conv_out_streamer_if.slave bus
);
  localparam int PIX = N * N;
  localparam int FW  = PIX * OUT_W;
  localparam int KW  = $clog2(PIX);
  localparam int RW  = $clog2(N);
  localparam logic [KW-1:0] KLAST = KW'(PIX - 1);
  localparam logic [RW-1:0] CLAST = RW'(N - 1);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t          state_q;
  logic [KW-1:0]   k_q;
  logic [RW-1:0]   row_q;
  logic [RW-1:0]   col_q;
  logic [FW-1:0]   active_q;
`ifdef CONV_STREAM_DBLBUF_EN
  logic [FW-1:0]   pend_q;
  logic            pend_full_q;
`endif

  logic cap_fire;
  logic beat_fire;
  logic last_beat;

  // All outputs decode registered state only; no input-to-output paths.
`ifdef CONV_STREAM_DBLBUF_EN
  assign bus.cap_ready = !pend_full_q;
`else
  assign bus.cap_ready = (state_q == IDLE);
`endif
  assign bus.m_valid = (state_q == STREAM);
  assign bus.m_data  = active_q[k_q*OUT_W +: OUT_W];
  assign bus.m_row   = row_q;
  assign bus.m_col   = col_q;
  assign bus.m_last  = (state_q == STREAM) && (k_q == KLAST);

  assign cap_fire  = bus.cap_valid && bus.cap_ready;
  assign beat_fire = bus.m_valid && bus.m_ready;
  assign last_beat = (k_q == KLAST);

  // Frame capture, pixel index / row / col counters and frame chaining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      row_q       <= '0;
      col_q       <= '0;
      active_q    <= '0;
`ifdef CONV_STREAM_DBLBUF_EN
      pend_q      <= '0;
      pend_full_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (cap_fire) begin
            active_q <= bus.conv_out;
            k_q      <= '0;
            row_q    <= '0;
            col_q    <= '0;
            state_q  <= STREAM;
          end
        end
        STREAM: begin
          if (beat_fire && !last_beat) begin
            k_q <= k_q + 1'b1;
            if (col_q == CLAST) begin
              col_q <= '0;
              row_q <= row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end else if (beat_fire) begin
            k_q   <= '0;
            row_q <= '0;
            col_q <= '0;
`ifdef CONV_STREAM_DBLBUF_EN
            // Held frame goes first; a same-edge capture refills pending.
            if (pend_full_q) begin
              active_q <= pend_q;
              if (cap_fire) pend_q <= bus.conv_out;
              else          pend_full_q <= 1'b0;
            end else if (cap_fire) begin
              active_q <= bus.conv_out;
            end else begin
              state_q <= IDLE;
            end
`else
            state_q <= IDLE;
`endif
          end
`ifdef CONV_STREAM_DBLBUF_EN
          if (cap_fire && !(beat_fire && last_beat)) begin
            pend_q      <= bus.conv_out;
            pend_full_q <= 1'b1;
          end
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_conv_out_streamer.sv
// Scoreboard bench for conv_out_streamer: captures push expected beats,
// a negedge monitor pops and compares every stream handshake.
module tb_conv_out_streamer;
  localparam int N     = 10;
  localparam int OUT_W = 2;
  localparam int PIX   = N * N;
  localparam int FW    = PIX * OUT_W;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic [3:0]       row;
    logic [3:0]       col;
    logic             last;
  } beat_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;
  beat_t sbq[$];
  int    lasts[$];

  conv_out_streamer_if #(.N(N), .OUT_W(OUT_W)) bus ();

  conv_out_streamer #(.N(N), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [FW-1:0] frame_of(input int kind);
    logic [FW-1:0] f;
    int v;
    f = '0;
    for (int k = 0; k < PIX; k++) begin
      case (kind)
        0:       v = k % 4;
        4:       v = (k / N) % 4;
        5:       v = (k * 3 + 1) % 4;
        default: v = kind;
      endcase
      f[k*OUT_W +: OUT_W] = OUT_W'(v);
    end
    return f;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input logic [FW-1:0] f);
    beat_t b;
    for (int k = 0; k < PIX; k++) begin
      b.data = f[k*OUT_W +: OUT_W];
      b.row  = 4'(k / N);
      b.col  = 4'(k % N);
      b.last = (k == PIX - 1);
      sbq.push_back(b);
    end
  endtask

  // Called at posedge+1; holds cap_valid until accepted.
  task automatic capture(input logic [FW-1:0] f, output int acc_cyc);
    bit ok;
    ok = 0;
    acc_cyc = -1;
    bus.conv_out  = f;
    bus.cap_valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.cap_ready) begin
        ok = 1;
        acc_cyc = cyc;
        push_frame(f);
        break;
      end
    end
    @(posedge clk); #1;
    bus.cap_valid = 1'b0;
    if (!ok) chk("capture_timeout", 0, 1);
  endtask

  task automatic wait_pos(input int r, input int c);
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (bus.m_valid && bus.m_row == 4'(r) && bus.m_col == 4'(c)) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk("wait_pos_timeout", 0, 1);
  endtask

  // Finds the next last-beat handshake; checks state in the following cycle.
  task automatic wait_done(input bit expect_idle);
    bit ok;
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.m_valid && bus.m_ready && bus.m_last) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk); #1;
    if (!ok) chk("last_timeout", 0, 1);
    else if (expect_idle) begin
      chk("after_last_m_valid", int'(bus.m_valid), 0);
      chk("after_last_cap_ready", int'(bus.cap_ready), 1);
    end else begin
      chk("chain_no_gap_m_valid", int'(bus.m_valid), 1);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && bus.m_valid && bus.m_ready) begin
      beat_t e;
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL beat_unexpected: got data=%0d row=%0d col=%0d last=%0d expected no beat",
                 bus.m_data, bus.m_row, bus.m_col, bus.m_last);
      end else begin
        e = sbq.pop_front();
        if (bus.m_data !== e.data || bus.m_row !== e.row ||
            bus.m_col !== e.col || bus.m_last !== e.last) begin
          failures++;
          $display("FAIL beat: got data=%0d row=%0d col=%0d last=%0d expected data=%0d row=%0d col=%0d last=%0d",
                   bus.m_data, bus.m_row, bus.m_col, bus.m_last,
                   e.data, e.row, e.col, e.last);
        end
      end
      if (bus.m_last) lasts.push_back(cyc);
    end
  end

  initial begin
    int c0, cb, cc;
    cyc = 0; checks = 0; failures = 0;
    rst_n = 1'b0;
    bus.cap_valid = 1'b0;
    bus.conv_out  = '0;
    bus.m_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid",   int'(bus.m_valid), 0);
    chk("rst_cap_ready", int'(bus.cap_ready), 1);
    chk("rst_m_data",    int'(bus.m_data), 0);
    chk("rst_m_row",     int'(bus.m_row), 0);
    chk("rst_m_col",     int'(bus.m_col), 0);
    chk("rst_m_last",    int'(bus.m_last), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic frame, full throughput
    lasts.delete();
    capture(frame_of(0), c0);
    chk("latency_m_valid", int'(bus.m_valid), 1);
    chk("pixel0_m_data", int'(bus.m_data), 0);
    wait_done(1);
    chk("frame_len", (lasts.size() > 0) ? lasts[0] - c0 : -1, PIX);

    // Backpressure at k=37
    capture(frame_of(0), c0);
    wait_pos(3, 7);
    bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_m_valid", int'(bus.m_valid), 1);
      chk("bp_m_data",  int'(bus.m_data), 1);
      chk("bp_m_row",   int'(bus.m_row), 3);
      chk("bp_m_col",   int'(bus.m_col), 7);
      @(posedge clk); #1;
    end
    bus.m_ready = 1'b1;
    wait_done(1);

`ifndef CONV_STREAM_DBLBUF_EN
    // Busy capture is ignored
    capture(frame_of(5), c0);
    wait_pos(5, 0);
    bus.conv_out  = frame_of(3);
    bus.cap_valid = 1'b1;
    @(negedge clk);
    chk("busy_cap_ready", int'(bus.cap_ready), 0);
    @(posedge clk); #1;
    bus.cap_valid = 1'b0;
    wait_done(1);
    capture(frame_of(3), c0);
    wait_done(1);
`endif

    // Reset mid-frame at k=60
    capture(frame_of(4), c0);
    wait_pos(6, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid",   int'(bus.m_valid), 0);
    chk("midrst_m_row",     int'(bus.m_row), 0);
    chk("midrst_m_col",     int'(bus.m_col), 0);
    chk("midrst_cap_ready", int'(bus.cap_ready), 1);
    sbq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_m_valid", int'(bus.m_valid), 0);
    capture(frame_of(5), c0);
    chk("restart_m_row", int'(bus.m_row), 0);
    chk("restart_m_col", int'(bus.m_col), 0);
    wait_done(1);

`ifdef CONV_STREAM_DBLBUF_EN
    // Three frames back-to-back: A streaming, B pending, C waits for A->B
    lasts.delete();
    capture(frame_of(1), c0);
    wait_pos(1, 0);
    capture(frame_of(2), cb);
    chk("dbl_b_accept_cyc", cb - c0, 11);
    capture(frame_of(3), cc);
    chk("dbl_c_accept_cyc", cc - c0, PIX + 1);
    wait_done(0);
    wait_done(1);
    chk("dbl_last_count", lasts.size(), 3);
    chk("dbl_last_a", (lasts.size() > 0) ? lasts[0] - c0 : -1, PIX);
    chk("dbl_last_b", (lasts.size() > 1) ? lasts[1] - c0 : -1, 2 * PIX);
    chk("dbl_last_c", (lasts.size() > 2) ? lasts[2] - c0 : -1, 3 * PIX);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sbq.size(), 0);
    chk("final_m_valid", int'(bus.m_valid), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
